// File: rtl/dmem_arb.sv
// Data-RAM arbiter: CPU M-stage port vs. display/switch debug read port.
// Grant is combinational; read data returns exactly one cycle after grant.
// Optional macro DMEM_ARB_STARVE_EN forces a debug grant after STARVE_MAX denials.
module dmem_arb #(
    parameter int ADDR_W     = 6,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

`ifdef DMEM_ARB_STARVE_EN
    localparam logic STARVE_EN = 1'b1;
`else
    // Strict CPU priority: the counter folds away to a constant zero.
    localparam logic STARVE_EN = 1'b0;
`endif

    // State records which grant was issued last cycle, so read data can be steered.
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] CPU_RD = 2'd1;
    localparam logic [1:0] CPU_WR = 2'd2;
    localparam logic [1:0] DBG_RD = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              cpu_gnt;
    logic              dbg_gnt_w;
    logic              force_dbg;

    // Arbitration: CPU wins unless the debug side has been starved to the limit.
    always_comb begin
        force_dbg = STARVE_EN && (starve_cnt_q == CNT_MAX);
        dbg_gnt_w = !rst && dbg_req && (!cpu_req || force_dbg);
        cpu_gnt   = !rst && cpu_req && !dbg_gnt_w;
        dbg_gnt   = dbg_gnt_w;
        cpu_stall = !rst && cpu_req && !cpu_gnt;
    end

    // RAM port mux; the address holds its last granted value when idle.
    always_comb begin
        ram_addr_d = ram_addr_q;
        if (cpu_gnt) begin
            ram_addr_d = cpu_addr;
        end else if (dbg_gnt_w) begin
            ram_addr_d = dbg_addr;
        end
        ram_addr  = ram_addr_d;
        ram_we    = cpu_gnt && cpu_we;
        ram_wdata = cpu_wdata;
    end

    // Next state is simply this cycle's grant; starvation counter update.
    always_comb begin
        state_d = IDLE;
        if (cpu_gnt) begin
            state_d = cpu_we ? CPU_WR : CPU_RD;
        end else if (dbg_gnt_w) begin
            state_d = DBG_RD;
        end

        starve_cnt_d = starve_cnt_q;
        if (!STARVE_EN || !dbg_req || dbg_gnt_w) begin
            starve_cnt_d = '0;
        end else if (cpu_gnt && (starve_cnt_q != CNT_MAX)) begin
            starve_cnt_d = starve_cnt_q + CNT_ONE;
        end
    end

    // Read return steering; reset squashes any read still in flight.
    always_comb begin
        cpu_rvalid = !rst && (state_q == CPU_RD);
        dbg_rvalid = !rst && (state_q == DBG_RD);
        cpu_rdata  = cpu_rvalid ? ram_rdata : '0;
        dbg_rdata  = dbg_rvalid ? ram_rdata : '0;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            ram_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            ram_addr_q   <= ram_addr_d;
        end
    end

endmodule

// File: doc/dmem_arb.md
DMEM_ARB -- requirements
Module: dmem_arb

Interface
REQ-001 The block SHALL take parameter ADDR_W, default 6, as the word-address width of the data RAM.
REQ-002 The block SHALL take parameter DATA_W, default 32, as the data word width.
REQ-003 The block SHALL take parameter STARVE_MAX, default 4, as the number of consecutive denied debug cycles before a forced debug grant.
REQ-004 The block SHALL have the following ports, one clock and a synchronous active-high reset:
- clk  in  1  sole clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_req  in  1  M-stage memory access request.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  word address.
- cpu_wdata  in  DATA_W  store data.
- cpu_stall  out  1  request not granted this cycle; pipeline holds.
- cpu_rvalid  out  1  CPU read data valid.
- cpu_rdata  out  DATA_W  CPU read data.
- dbg_req  in  1  display/switch read request; held until granted.
- dbg_addr  in  ADDR_W  debug word address; stable while dbg_req is high.
- dbg_gnt  out  1  debug request accepted this cycle.
- dbg_rvalid  out  1  debug read data valid.
- dbg_rdata  out  DATA_W  debug read data.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data, one-cycle synchronous-read latency.

Function
REQ-005 The block SHALL grant at most one requester per cycle; the grant SHALL be combinational from the current inputs and the registered state.
REQ-006 Default priority SHALL be CPU over debug.
REQ-007 A debug grant SHALL occur when dbg_req is high and either cpu_req is low or starve_cnt equals STARVE_MAX.
REQ-008 cpu_stall SHALL equal cpu_req AND NOT (CPU granted).
REQ-009 On a CPU grant, ram_addr SHALL equal cpu_addr, ram_we SHALL equal cpu_we, and ram_wdata SHALL equal cpu_wdata.
REQ-010 On a debug grant, ram_addr SHALL equal dbg_addr and ram_we SHALL be 0.
REQ-011 With no grant, ram_we SHALL be 0 and ram_addr SHALL hold its last granted value.
REQ-012 A registered state machine SHALL record the grant issued in each cycle, with states IDLE, CPU_RD, CPU_WR and DBG_RD; the next state SHALL be the grant issued in the current cycle, or IDLE when there is no grant.
REQ-013 In state CPU_RD, cpu_rvalid SHALL be 1 and cpu_rdata SHALL equal ram_rdata; otherwise cpu_rvalid SHALL be 0 and cpu_rdata SHALL be 0.
REQ-014 In state DBG_RD, dbg_rvalid SHALL be 1 and dbg_rdata SHALL equal ram_rdata; otherwise dbg_rvalid SHALL be 0 and dbg_rdata SHALL be 0.
REQ-015 Read latency SHALL be exactly one cycle from grant to rvalid, for both requesters.
REQ-016 starve_cnt SHALL have width clog2(STARVE_MAX+1), with the following update rules:
- It SHALL increment when dbg_req is high and the CPU is granted.
- It SHALL clear on a debug grant or when dbg_req is low.
- It SHALL saturate at STARVE_MAX.
REQ-017 When a CPU write at address A is granted in cycle N and a debug read of A is granted in cycle N+1, the debug read SHALL return the newly written data.
REQ-018 When cpu_req and dbg_req are both high with starve_cnt below STARVE_MAX, the CPU SHALL be granted and dbg_gnt SHALL be 0.

Reset
REQ-019 While rst is high, the following outputs SHALL be forced:
- The state SHALL be IDLE and starve_cnt SHALL be 0.
- dbg_gnt, ram_we, cpu_stall, cpu_rvalid and dbg_rvalid SHALL be 0.
- cpu_rdata and dbg_rdata SHALL be 0.
REQ-020 A read granted in the cycle before rst asserts SHALL be discarded, with no rvalid after reset.
REQ-021 In the first cycle after rst deasserts, arbitration SHALL resume normally.

Configuration
REQ-022 Macro DMEM_ARB_STARVE_EN SHALL select the debug starvation behaviour:
- Defined: starvation forcing per REQ-007 and REQ-016 SHALL be active.
- Undefined: strict CPU priority SHALL apply; the debug requester SHALL be granted only when cpu_req is low; starve_cnt SHALL be absent or held at 0.

Verification
REQ-023 Read response: CPU read of address 5 (RAM holds 0x1234_5678) -> cpu_stall 0, cpu_rvalid 1 next cycle, cpu_rdata 0x1234_5678.
REQ-024 Write then debug read: CPU write 0xDEADBEEF to address 9, then debug read of address 9 -> dbg_gnt asserted in the cycle after the write, dbg_rdata 0xDEADBEEF one cycle later.
REQ-025 Forced debug grant: cpu_req and dbg_req held high, STARVE_MAX=4, macro defined -> CPU granted 4 cycles, 5th cycle dbg_gnt 1 and cpu_stall 1, then CPU granted again.
REQ-026 Strict priority: same stimulus as REQ-025 with macro undefined -> dbg_gnt stays 0 until cpu_req drops, then 1 in that cycle.
REQ-027 Reset mid-read: rst pulsed in the cycle after a CPU read grant -> cpu_rvalid 0, all outputs 0, starve_cnt 0.
